// File: rtl/ysyx_210238_lsu_pkg.sv
// ysyx_210238_lsu_pkg: shared ls_info indices, FSM states, size codes and decode helpers for the LSU
package ysyx_210238_lsu_pkg;
   localparam int LS_SD  = 0;
   localparam int LS_SW  = 1;
   localparam int LS_SH  = 2;
   localparam int LS_SB  = 3;
   localparam int LS_LWU = 4;
   localparam int LS_LHU = 5;
   localparam int LS_LBU = 6;
   localparam int LS_LD  = 7;
   localparam int LS_LW  = 8;
   localparam int LS_LH  = 9;
   localparam int LS_LB  = 10;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;
   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RSP  = 2'd2
   } lsu_state_t;
   typedef struct packed {
      logic [1:0] size;
      logic       sign;
   } ls_dec_t;
   // Scan from the top so the lowest-index set bit is the one that sticks.
   function automatic ls_dec_t ls_decode(input logic [10:0] info);
      ls_dec_t d;
      d = '{size: SZ_B, sign: 1'b0};
      for (int i = 10; i >= 0; i--)
         if (info[i])
            d = '{size: (i == LS_LB || i == LS_LBU || i == LS_SB) ? SZ_B :
                        (i == LS_LH || i == LS_LHU || i == LS_SH) ? SZ_H :
                        (i == LS_LW || i == LS_LWU || i == LS_SW) ? SZ_W : SZ_D,
                  sign: i >= LS_LW};
      return d;
   endfunction
   function automatic logic [2:0] size_mask(input logic [1:0] sz);
      return sz == SZ_B ? 3'b111 : sz == SZ_H ? 3'b110 : sz == SZ_W ? 3'b100 : 3'b000;
   endfunction
   function automatic logic [7:0] size_strb(input logic [1:0] sz);
      return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
   endfunction
endpackage

// File: rtl/ysyx_210238_lsu_align.sv
// ysyx_210238_lsu_align: byte-lane placement of store data/strobes and extraction/extension of load data
module ysyx_210238_lsu_align
   import ysyx_210238_lsu_pkg::*;
(
   input  logic [2:0]  st_off,
   input  logic [1:0]  st_size,
   input  logic [63:0] st_data,
   output logic [63:0] st_wdata,
   output logic [7:0]  st_wstrb,
   input  logic [2:0]  ld_off,
   input  logic [1:0]  ld_size,
   input  logic        ld_sign,
   input  logic [63:0] ld_rdata,
   output logic [63:0] ld_data
);
   logic [63:0] sh;
   always_comb begin
      st_wdata = st_data << {st_off, 3'b000};
      st_wstrb = size_strb(st_size) << st_off;
      sh = ld_rdata >> {ld_off, 3'b000};
      ld_data = ld_size == SZ_B ? {{56{ld_sign & sh[7]}}, sh[7:0]} :
                ld_size == SZ_H ? {{48{ld_sign & sh[15]}}, sh[15:0]} :
                ld_size == SZ_W ? {{32{ld_sign & sh[31]}}, sh[31:0]} : sh;
   end
endmodule

// File: rtl/ysyx_210238_lsu.sv
// ysyx_210238_lsu: load/store stage; issues one memory request per bundle, stalls until done, registers WB result
module ysyx_210238_lsu
   import ysyx_210238_lsu_pkg::*;
#(
   parameter int MEM_AW        = 64,
   parameter bit MISALIGN_TRAP = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [63:0]       i_mem_addr,
   input  logic [63:0]       i_mem_wdata,
   input  logic [10:0]       i_ls_info,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_rd_wen,
   input  logic [4:0]        i_rd_addr,
   input  logic [63:0]       i_rd_data,
   output logic              o_stall,
   output logic              o_mem_req_valid,
   input  logic              i_mem_req_ready,
   output logic [MEM_AW-1:0] o_mem_req_addr,
   output logic              o_mem_req_wen,
   output logic [63:0]       o_mem_req_wdata,
   output logic [7:0]        o_mem_req_wstrb,
   input  logic              i_mem_rsp_valid,
   input  logic [63:0]       i_mem_rsp_rdata,
   output logic              o_wb_valid,
   output logic              o_rd_wen,
   output logic [4:0]        o_rd_addr,
   output logic [63:0]       o_rd_data,
   output logic              o_misalign
);
   lsu_state_t  state;
   ls_dec_t     dec;
   logic        mem_op, mis, trap, done, load_q, sign_q;
   logic [2:0]  off, off_q;
   logic [1:0]  size_q;
   logic [63:0] st_wdata, ld_data;
   logic [7:0]  st_wstrb;

   // Masking the offset by size gives the cleared-low-bits address when misaligned accesses are not trapped.
   assign dec    = ls_decode(i_ls_info);
   assign off    = i_mem_addr[2:0] & size_mask(dec.size);
   assign mis    = off != i_mem_addr[2:0];
   assign mem_op = i_mem_read | i_mem_write;
   assign trap   = MISALIGN_TRAP & mem_op & mis;
   assign done   = i_mem_rsp_valid & ((state == LSU_REQ & i_mem_req_ready) | (state == LSU_RSP));
   assign o_stall = i_rst_n & ((state == LSU_IDLE) ? (i_valid & mem_op & !trap) : !done);

   ysyx_210238_lsu_align u_align (
      .st_off   (off),
      .st_size  (dec.size),
      .st_data  (i_mem_wdata),
      .st_wdata (st_wdata),
      .st_wstrb (st_wstrb),
      .ld_off   (off_q),
      .ld_size  (size_q),
      .ld_sign  (sign_q),
      .ld_rdata (i_mem_rsp_rdata),
      .ld_data  (ld_data)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= LSU_IDLE;
         o_mem_req_valid <= 1'b0;
         o_mem_req_addr  <= '0;
         o_mem_req_wen   <= 1'b0;
         o_mem_req_wdata <= '0;
         o_mem_req_wstrb <= '0;
         o_wb_valid      <= 1'b0;
         o_rd_wen        <= 1'b0;
         o_rd_addr       <= '0;
         o_rd_data       <= '0;
         o_misalign      <= 1'b0;
         off_q           <= '0;
         size_q          <= SZ_B;
         sign_q          <= 1'b0;
         load_q          <= 1'b0;
      end else begin
         o_wb_valid <= done;
         o_misalign <= 1'b0;
         if (state == LSU_IDLE && i_valid) begin
            o_rd_wen   <= i_rd_wen & !trap;
            o_rd_addr  <= i_rd_addr;
            o_rd_data  <= i_rd_data;
            o_wb_valid <= !mem_op | trap;
            o_misalign <= trap;
            if (mem_op && !trap) begin
               state           <= LSU_REQ;
               o_mem_req_valid <= 1'b1;
               o_mem_req_addr  <= {i_mem_addr[MEM_AW-1:3], 3'b000};
               o_mem_req_wen   <= i_mem_write;
               o_mem_req_wdata <= i_mem_write ? st_wdata : '0;
               o_mem_req_wstrb <= i_mem_write ? st_wstrb : '0;
               off_q           <= off;
               size_q          <= dec.size;
               sign_q          <= dec.sign;
               load_q          <= !i_mem_write;
            end
         end
         if (state == LSU_REQ && i_mem_req_ready) begin
            o_mem_req_valid <= 1'b0;
            state           <= i_mem_rsp_valid ? LSU_IDLE : LSU_RSP;
         end
         if (done) begin
            state <= LSU_IDLE;
            if (load_q) o_rd_data <= ld_data;
         end
      end
   end
endmodule

// File: tb/tb_ysyx_210238_lsu.sv
// tb_ysyx_210238_lsu: table-driven bench with a WB scoreboard and an inline memory responder
module tb_ysyx_210238_lsu;
   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0;
   logic [63:0] i_mem_addr = '0, i_mem_wdata = '0, i_rd_data = '0, i_mem_rsp_rdata = '0;
   logic [10:0] i_ls_info = '0;
   logic        i_mem_read = 1'b0, i_mem_write = 1'b0, i_rd_wen = 1'b0;
   logic [4:0]  i_rd_addr = '0;
   logic        i_mem_req_ready = 1'b0, i_mem_rsp_valid = 1'b0;
   logic        o_stall, o_mem_req_valid, o_mem_req_wen, o_wb_valid, o_rd_wen, o_misalign;
   logic [63:0] o_mem_req_addr, o_mem_req_wdata, o_rd_data;
   logic [7:0]  o_mem_req_wstrb;
   logic [4:0]  o_rd_addr;

   typedef struct {
      logic [10:0] info;
      logic        rd, wr;
      logic [63:0] addr, wdata, rsp, rd_data;
      logic        rd_wen;
      logic [4:0]  rd_addr;
      int          rdy_w, rsp_w;
      logic [63:0] e_addr, e_wdata;
      logic [7:0]  e_wstrb;
      logic [63:0] e_data;
      logic        e_wen, e_mis;
   } vec_t;
   typedef struct {
      logic [63:0] data;
      logic        wen;
      logic [4:0]  addr;
      logic        mis, chk_data;
      int          due;
   } wb_t;

   vec_t tbl[16];
   wb_t  wb_q[$];
   int   tests = 0, fails = 0, cyc = 0;

   ysyx_210238_lsu dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_mem_addr(i_mem_addr),
      .i_mem_wdata(i_mem_wdata), .i_ls_info(i_ls_info), .i_mem_read(i_mem_read),
      .i_mem_write(i_mem_write), .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr),
      .i_rd_data(i_rd_data), .o_stall(o_stall), .o_mem_req_valid(o_mem_req_valid),
      .i_mem_req_ready(i_mem_req_ready), .o_mem_req_addr(o_mem_req_addr),
      .o_mem_req_wen(o_mem_req_wen), .o_mem_req_wdata(o_mem_req_wdata),
      .o_mem_req_wstrb(o_mem_req_wstrb), .i_mem_rsp_valid(i_mem_rsp_valid),
      .i_mem_rsp_rdata(i_mem_rsp_rdata), .o_wb_valid(o_wb_valid), .o_rd_wen(o_rd_wen),
      .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_misalign(o_misalign)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   always @(negedge i_clk) begin
      if (o_wb_valid) begin
         if (wb_q.size() == 0) chk("wb_unexpected", o_wb_valid, 1'b0);
         else begin
            wb_t w;
            w = wb_q.pop_front();
            chk("wb_cycle", cyc, w.due);
            chk("wb_rd_wen", o_rd_wen, w.wen);
            chk("wb_rd_addr", o_rd_addr, w.addr);
            chk("wb_misalign", o_misalign, w.mis);
            if (w.chk_data) chk("wb_rd_data", o_rd_data, w.data);
         end
      end
   end

   task automatic run(input vec_t v);
      wb_t  w;
      logic mem;
      mem = v.rd | v.wr;
      w = '{v.e_data, v.e_wen, v.rd_addr, v.e_mis, !v.e_mis, 0};
      @(negedge i_clk);
      i_valid = 1'b1; i_ls_info = v.info; i_mem_read = v.rd; i_mem_write = v.wr;
      i_mem_addr = v.addr; i_mem_wdata = v.wdata; i_rd_wen = v.rd_wen;
      i_rd_addr = v.rd_addr; i_rd_data = v.rd_data; i_mem_rsp_rdata = v.rsp;
      #1 chk("stall_on_issue", o_stall, mem && !v.e_mis);
      if (!mem || v.e_mis) begin
         w.due = cyc + 1;
         wb_q.push_back(w);
         @(negedge i_clk);
         i_valid = 1'b0;
         chk("no_req", o_mem_req_valid, 1'b0);
         return;
      end
      for (int k = 0; k <= v.rdy_w; k++) begin
         @(negedge i_clk);
         chk("req_valid", o_mem_req_valid, 1'b1);
         chk("req_addr", o_mem_req_addr, v.e_addr);
         chk("req_stall", o_stall, 1'b1);
         if (k == 0) begin
            chk("req_wen", o_mem_req_wen, v.wr);
            chk("req_wstrb", o_mem_req_wstrb, v.e_wstrb);
            if (v.wr) chk("req_wdata", o_mem_req_wdata, v.e_wdata);
         end
         i_mem_req_ready = k == v.rdy_w;
         i_mem_rsp_valid = k == v.rdy_w && v.rsp_w == 0;
      end
      #1 chk("accept_stall", o_stall, v.rsp_w != 0);
      if (v.rsp_w == 0) begin
         w.due = cyc + 1;
         wb_q.push_back(w);
      end
      for (int j = 1; j <= v.rsp_w; j++) begin
         @(negedge i_clk);
         i_mem_req_ready = 1'b0;
         chk("rsp_wait_stall", o_stall, 1'b1);
         if (j == 1) chk("req_dropped", o_mem_req_valid, 1'b0);
         if (j == v.rsp_w) begin
            i_mem_rsp_valid = 1'b1;
            #1 chk("rsp_stall_drop", o_stall, 1'b0);
            w.due = cyc + 1;
            wb_q.push_back(w);
         end
      end
      @(negedge i_clk);
      i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_valid = 1'b0;
      chk("idle_req_valid", o_mem_req_valid, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{11'h008, 0, 1, 64'h1003, 64'hAB, 0, 64'h55, 0, 5'd0, 0, 1, 64'h1000, 64'hAB00_0000, 8'h08, 64'h55, 0, 0};
      tbl[1]  = '{11'h400, 1, 0, 64'h2006, 0, 64'h0080_0000_0000_0000, 0, 1, 5'd7, 0, 1, 64'h2000, 0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1, 0};
      tbl[2]  = '{11'h040, 1, 0, 64'h2006, 0, 64'h0080_0000_0000_0000, 0, 1, 5'd8, 1, 2, 64'h2000, 0, 8'h00, 64'h80, 1, 0};
      tbl[3]  = '{11'h100, 1, 0, 64'h2002, 0, 0, 64'h99, 1, 5'd9, 0, 0, 0, 0, 8'h00, 0, 0, 1};
      tbl[4]  = '{11'h080, 1, 0, 64'h3000, 0, 64'hCAFE_BABE_1234_5678, 0, 1, 5'd10, 3, 2, 64'h3000, 0, 8'h00, 64'hCAFE_BABE_1234_5678, 1, 0};
      tbl[5]  = '{11'h000, 0, 0, 0, 0, 0, 64'h1234, 1, 5'd5, 0, 0, 0, 0, 8'h00, 64'h1234, 1, 0};
      tbl[6]  = '{11'h004, 0, 1, 64'h100A, 64'hBEEF, 0, 0, 0, 5'd0, 0, 0, 64'h1008, 64'hBEEF_0000, 8'h0C, 0, 0, 0};
      tbl[7]  = '{11'h002, 0, 1, 64'h1004, 64'hDEAD_BEEF, 0, 64'h11, 0, 5'd0, 1, 1, 64'h1000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h11, 0, 0};
      tbl[8]  = '{11'h001, 0, 1, 64'h1008, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 5'd0, 2, 0, 64'h1008, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 0};
      tbl[9]  = '{11'h200, 1, 0, 64'h2004, 0, 64'h0000_8001_0000_0000, 0, 1, 5'd11, 0, 1, 64'h2000, 0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 1, 0};
      tbl[10] = '{11'h020, 1, 0, 64'h2004, 0, 64'h0000_8001_0000_0000, 0, 1, 5'd12, 0, 1, 64'h2000, 0, 8'h00, 64'h8001, 1, 0};
      tbl[11] = '{11'h100, 1, 0, 64'h2004, 0, 64'h8000_0000_1234_5678, 0, 1, 5'd13, 1, 1, 64'h2000, 0, 8'h00, 64'hFFFF_FFFF_8000_0000, 1, 0};
      tbl[12] = '{11'h010, 1, 0, 64'h2004, 0, 64'h8000_0000_1234_5678, 0, 1, 5'd14, 0, 0, 64'h2000, 0, 8'h00, 64'h8000_0000, 1, 0};
      tbl[13] = '{11'h080, 1, 0, 64'h3004, 0, 0, 0, 1, 5'd15, 0, 0, 0, 0, 8'h00, 0, 0, 1};
      tbl[14] = '{11'h004, 0, 1, 64'h1001, 64'h7777, 0, 0, 1, 5'd16, 0, 0, 0, 0, 8'h00, 0, 0, 1};
      tbl[15] = '{11'h000, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd31, 0, 0, 0, 0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
      #3;
      chk("rst_stall", o_stall, 1'b0);
      chk("rst_req_valid", o_mem_req_valid, 1'b0);
      chk("rst_req_wstrb", o_mem_req_wstrb, 8'h00);
      chk("rst_wb_valid", o_wb_valid, 1'b0);
      chk("rst_rd_data", o_rd_data, 64'h0);
      chk("rst_misalign", o_misalign, 1'b0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int i = 0; i < 16; i++) run(tbl[i]);
      // Reset pulse while waiting in RSP; the late response must be dropped.
      @(negedge i_clk);
      i_valid = 1'b1; i_ls_info = 11'h080; i_mem_read = 1'b1; i_mem_write = 1'b0;
      i_mem_addr = 64'h3000; i_rd_wen = 1'b1; i_rd_addr = 5'd3; i_rd_data = 64'h77;
      @(negedge i_clk);
      i_mem_req_ready = 1'b1;
      @(negedge i_clk);
      i_mem_req_ready = 1'b0;
      chk("rsp_state_stall", o_stall, 1'b1);
      #2 i_rst_n = 1'b0; i_valid = 1'b0;
      #1;
      chk("midrst_stall", o_stall, 1'b0);
      chk("midrst_req_valid", o_mem_req_valid, 1'b0);
      chk("midrst_rd_wen", o_rd_wen, 1'b0);
      chk("midrst_rd_addr", o_rd_addr, 5'd0);
      chk("midrst_rd_data", o_rd_data, 64'h0);
      chk("midrst_wb_valid", o_wb_valid, 1'b0);
      @(negedge i_clk);
      i_rst_n = 1'b1; i_mem_rsp_valid = 1'b1; i_mem_rsp_rdata = 64'hDEAD;
      #1 chk("late_rsp_stall", o_stall, 1'b0);
      @(negedge i_clk);
      i_mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_rsp_wb_valid", o_wb_valid, 1'b0);
         chk("late_rsp_req_valid", o_mem_req_valid, 1'b0);
         @(negedge i_clk);
      end
      // After the reset the stage must still serve a plain bundle.
      run('{11'h000, 0, 0, 0, 0, 0, 64'h4242, 1, 5'd4, 0, 0, 0, 0, 8'h00, 64'h4242, 1, 0});
      repeat (3) @(negedge i_clk);
      chk("wb_queue_drained", wb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
